prng_arb_ctrl: RTL and testbench

Sequencer and arbiter for the shared 25-bit LFSR PRNG (x^25 + x^3 + 1).
- Drives the PRNG command interface (halt/shift/seed-load) and serves multiple requesters round-robin.
- For each request, advances the LFSR by a configurable number of shifts and returns the resulting word.
- Seed loads take priority over word requests.
- Sits between the instruction decoder/seed source and consumers such as the error-vector and permutation units.

---
 rtl/prng_arb_ctrl.sv | 170 +++++++++++++++++
 tb/tb_prng_arb_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_arb_ctrl.sv
// Round-robin sequencer for the shared 25-bit LFSR PRNG: seed loads and N-shift word requests.
// Optional PRNG_ZERO_GUARD_EN forces all-zero seeds to 1 and adds the seed_zero_err pulse.
module prng_arb_ctrl #(
    parameter int NREQ   = 2,
    parameter int DAT_W  = 25,
    parameter int TYP_W  = 2,
    parameter int STEP_W = 5
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              seed_req,
    input  logic [DAT_W-1:0]  seed_dat,
    output logic              seed_ack,
    output logic              seeded,
`ifdef PRNG_ZERO_GUARD_EN
    output logic              seed_zero_err,
`endif
    input  logic [STEP_W-1:0] cfg_steps,
    input  logic [NREQ-1:0]   req_vld,
    output logic [NREQ-1:0]   rsp_vld,
    output logic [DAT_W-1:0]  rsp_dat,
    output logic [TYP_W-1:0]  prng_typ_sel,
    output logic [DAT_W-1:0]  prng_t_dat,
    output logic              prng_t_sel,
    input  logic [DAT_W-1:0]  prng_r_dat,
    output logic [2:0]        dbg_state
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW    = IDX_W + 1;

    // Requester handshake: req_vld[i] is a level held until rsp_vld[i]; rsp_vld is a one-cycle
    // one-hot pulse with rsp_dat valid in the same cycle. There is no back-pressure on responses.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEED_LD   = 3'd1,
        ST_SEED_WAIT = 3'd2,
        ST_SEED_ACK  = 3'd3,
        ST_SHIFT     = 3'd4,
        ST_DRAIN     = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [DAT_W-1:0]    seed_q, seed_d;
    logic                seeded_q, seeded_d;
    logic                zero_q, zero_d;

    logic                pick_vld;
    logic [IDX_W-1:0]    pick_idx;
    logic [CW-1:0]       cand_w;
    logic [STEP_W-1:0]   steps_n;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            gnt_q    <= '0;
            cnt_q    <= '0;
            seed_q   <= '0;
            seeded_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            seed_q   <= seed_d;
            seeded_q <= seeded_d;
            zero_q   <= zero_d;
        end
    end

    // First requester at or after the round-robin pointer, wrapping at NREQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand_w   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_w = {1'b0, rr_q} + CW'(i);
            if (cand_w >= CW'(NREQ)) begin
                cand_w = cand_w - CW'(NREQ);
            end
            if (!pick_vld && req_vld[cand_w[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = cand_w[IDX_W-1:0];
            end
        end
    end

    assign steps_n = (cfg_steps == '0) ? STEP_W'(DAT_W) : cfg_steps;

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        seed_d   = seed_q;
        seeded_d = seeded_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (seed_req) begin
                    seed_d  = seed_dat;
                    zero_d  = 1'b0;
`ifdef PRNG_ZERO_GUARD_EN
                    if (seed_dat == '0) begin
                        seed_d = DAT_W'(1);
                        zero_d = 1'b1;
                    end
`endif
                    state_d = ST_SEED_LD;
                end else if (pick_vld) begin
                    gnt_d   = pick_idx;
                    cnt_d   = steps_n - STEP_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SEED_LD:   state_d = ST_SEED_WAIT;
            ST_SEED_WAIT: begin
                seeded_d = 1'b1;
                state_d  = ST_SEED_ACK;
            end
            ST_SEED_ACK:  state_d = ST_IDLE;
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q - STEP_W'(1);
                end
            end
            ST_DRAIN:     state_d = ST_DONE;
            ST_DONE: begin
                rr_d    = (gnt_q == IDX_W'(NREQ - 1)) ? '0 : gnt_q + IDX_W'(1);
                state_d = ST_IDLE;
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        seed_ack     = (state_q == ST_SEED_ACK);
        seeded       = seeded_q;
        rsp_vld      = '0;
        rsp_dat      = '0;
        prng_typ_sel = TYP_W'(0);
        prng_t_sel   = 1'b0;
        prng_t_dat   = seed_q;
        dbg_state    = state_q;
`ifdef PRNG_ZERO_GUARD_EN
        seed_zero_err = (state_q == ST_SEED_ACK) && zero_q;
`endif
        case (state_q)
            ST_SEED_LD: begin
                prng_typ_sel = TYP_W'(2);
                prng_t_sel   = 1'b1;
            end
            ST_SHIFT: prng_typ_sel = TYP_W'(1);
            ST_DONE: begin
                rsp_vld[gnt_q] = 1'b1;
                rsp_dat        = prng_r_dat;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_prng_arb_ctrl.sv
// Directed bench for prng_arb_ctrl with a behavioural model of the registered-command LFSR.
module tb_prng_arb_ctrl;

  localparam int NREQ   = 2;
  localparam int DAT_W  = 25;
  localparam int TYP_W  = 2;
  localparam int STEP_W = 5;

  logic              clk;
  logic              rst_b;
  logic              seed_req;
  logic [DAT_W-1:0]  seed_dat;
  logic              seed_ack;
  logic              seeded;
`ifdef PRNG_ZERO_GUARD_EN
  logic              seed_zero_err;
`endif
  logic [STEP_W-1:0] cfg_steps;
  logic [NREQ-1:0]   req_vld;
  logic [NREQ-1:0]   rsp_vld;
  logic [DAT_W-1:0]  rsp_dat;
  logic [TYP_W-1:0]  prng_typ_sel;
  logic [DAT_W-1:0]  prng_t_dat;
  logic              prng_t_sel;
  logic [DAT_W-1:0]  prng_r_dat;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DAT_W-1:0] exp_q[$];

  prng_arb_ctrl #(.NREQ(NREQ), .DAT_W(DAT_W), .TYP_W(TYP_W), .STEP_W(STEP_W)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .seed_req     (seed_req),
    .seed_dat     (seed_dat),
    .seed_ack     (seed_ack),
    .seeded       (seeded),
`ifdef PRNG_ZERO_GUARD_EN
    .seed_zero_err(seed_zero_err),
`endif
    .cfg_steps    (cfg_steps),
    .req_vld      (req_vld),
    .rsp_vld      (rsp_vld),
    .rsp_dat      (rsp_dat),
    .prng_typ_sel (prng_typ_sel),
    .prng_t_dat   (prng_t_dat),
    .prng_t_sel   (prng_t_sel),
    .prng_r_dat   (prng_r_dat),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // PRNG model: command registered, applied one cycle later; x^25 + x^3 + 1, shift left.
  logic [TYP_W-1:0] cmd_q;
  logic             tsel_q;
  logic [DAT_W-1:0] tdat_q;
  logic [DAT_W-1:0] lfsr_q;

  always @(posedge clk) begin
    if (!rst_b) begin
      cmd_q  <= '0;
      tsel_q <= 1'b0;
      tdat_q <= '0;
      lfsr_q <= '0;
    end else begin
      cmd_q  <= prng_typ_sel;
      tsel_q <= prng_t_sel;
      tdat_q <= prng_t_dat;
      if (cmd_q == 2'd2 && tsel_q) lfsr_q <= tdat_q;
      else if (cmd_q == 2'd1) lfsr_q <= {lfsr_q[DAT_W-2:0], lfsr_q[24] ^ lfsr_q[2]};
    end
  end
  assign prng_r_dat = lfsr_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_seed_ack"}, 32'(seed_ack), 0);
    chk({nm, "_seeded"}, 32'(seeded), 0);
    chk({nm, "_rsp_vld"}, 32'(rsp_vld), 0);
    chk({nm, "_rsp_dat"}, 32'(rsp_dat), 0);
    chk({nm, "_typ_sel"}, 32'(prng_typ_sel), 0);
    chk({nm, "_t_dat"}, 32'(prng_t_dat), 0);
    chk({nm, "_t_sel"}, 32'(prng_t_sel), 0);
    chk({nm, "_state"}, 32'(dbg_state), 0);
  endtask

  // driver tasks: inputs change on negedge, outputs sampled on negedge
  task automatic do_reset();
    rst_b = 1'b0; seed_req = 1'b0; req_vld = '0; seed_dat = '0; cfg_steps = '0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic seed_load(input logic [DAT_W-1:0] sd, input logic [DAT_W-1:0] exp_r,
                           input bit exp_zero);
    int tsel_cnt;
    bit got;
    seed_req = 1'b1; seed_dat = sd; tsel_cnt = 0; got = 1'b0;
    for (int k = 1; k <= 10 && !got; k++) begin
      @(negedge clk);
      seed_req = 1'b0;
      seed_dat = ~sd;
      if (prng_t_sel) tsel_cnt++;
      if (k == 1) begin
        chk("seed_t_dat", 32'(prng_t_dat), 32'(exp_r));
        chk("seed_typ_load", 32'(prng_typ_sel), 2);
      end
      if (seed_ack) begin
        got = 1'b1;
        chk("seed_ack_lat", k, 3);
        chk("seed_r_dat", 32'(prng_r_dat), 32'(exp_r));
`ifdef PRNG_ZERO_GUARD_EN
        chk("seed_zero_err", 32'(seed_zero_err), 32'(exp_zero));
`else
        chk("seed_zero_none", 32'(exp_zero), 0);
`endif
      end
    end
    chk("seed_ack_seen", 32'(got), 1);
    chk("seed_tsel_cnt", tsel_cnt, 1);
    @(negedge clk);
    chk("seed_ack_drop", 32'(seed_ack), 0);
    chk("seeded_set", 32'(seeded), 1);
    chk("seed_idle", 32'(dbg_state), 0);
  endtask

  task automatic word(input int r, input logic [STEP_W-1:0] st, input logic [DAT_W-1:0] exp);
    int n;
    int shifts;
    bit got;
    bit idle_dat_bad;
    n = (st == 0) ? DAT_W : int'(st);
    exp_q.push_back(exp);
    req_vld[r] = 1'b1; cfg_steps = st; got = 1'b0; shifts = 0; idle_dat_bad = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      cfg_steps = st + STEP_W'(7);
      if (prng_typ_sel == 2'd1) shifts++;
      if (rsp_vld != '0) begin
        got = 1'b1;
        req_vld[r] = 1'b0;
        chk("word_lat", k, n + 2);
        chk("word_onehot", 32'(rsp_vld), 32'(1) << r);
        chk("word_dat", 32'(rsp_dat), 32'(exp_q.pop_front()));
      end else if (rsp_dat != '0) begin
        idle_dat_bad = 1'b1;
      end
    end
    chk("word_seen", 32'(got), 1);
    chk("word_shifts", shifts, n);
    chk("word_dat_gated", 32'(idle_dat_bad), 0);
    @(negedge clk);
    chk("word_idle", 32'(dbg_state), 0);
  endtask

  typedef struct {
    bit               do_seed;
    logic [DAT_W-1:0] seed;
    logic [STEP_W-1:0] steps;
    int               req;
    logic [DAT_W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [DAT_W-1:0] guard_seed;
    logic [DAT_W-1:0] zero_word;
    bit               zero_flag;
    int               ack_k;
    int               rsp_k;
    int               cnt;
    int               last_k;
    int               k;

`ifdef PRNG_ZERO_GUARD_EN
    guard_seed = 25'h0000001; zero_word = 25'h0000012; zero_flag = 1'b1;
`else
    guard_seed = 25'h0000000; zero_word = 25'h0000000; zero_flag = 1'b0;
`endif

    vecs[0] = '{1'b0, 25'h0000000, 5'd4, 0, 25'h0000000};  // before any seed: all-zero LFSR
    vecs[1] = '{1'b1, 25'h0000001, 5'd3, 0, 25'h0000009};
    vecs[2] = '{1'b1, 25'h1000000, 5'd1, 1, 25'h0000001};
    vecs[3] = '{1'b1, 25'h0000001, 5'd0, 1, 25'h0492493};  // 0 steps means 25 shifts
    vecs[4] = '{1'b1, 25'h0000001, 5'd5, 0, 25'h0000024};
    vecs[5] = '{1'b1, 25'h0000005, 5'd1, 1, 25'h000000B};
    vecs[6] = '{1'b1, 25'h1000004, 5'd1, 0, 25'h0000008};
    vecs[7] = '{1'b1, 25'h1000000, 5'd2, 1, 25'h0000002};
    vecs[8] = '{1'b0, 25'h0000000, 5'd1, 0, 25'h0000004};  // continues from 0x0000002
    vecs[9] = '{1'b1, 25'h0000000, 5'd4, 0, zero_word};

    do_reset();
    @(negedge clk);
    chk_outputs_zero("reset");

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].do_seed) begin
        if (vecs[i].seed == '0) seed_load(vecs[i].seed, guard_seed, zero_flag);
        else seed_load(vecs[i].seed, vecs[i].seed, 1'b0);
      end
      word(vecs[i].req, vecs[i].steps, vecs[i].exp);
    end

    // seed and word requested in the same IDLE cycle: seed first
    seed_req = 1'b1; seed_dat = 25'h0000001; req_vld = 2'b01; cfg_steps = 5'd3;
    ack_k = 0; rsp_k = 0;
    for (k = 1; k <= 30 && rsp_k == 0; k++) begin
      @(negedge clk);
      seed_req = 1'b0;
      if (seed_ack && ack_k == 0) ack_k = k;
      if (rsp_vld != '0) begin
        rsp_k = k;
        req_vld = '0;
        chk("both_rsp_vld", 32'(rsp_vld), 1);
        chk("both_rsp_dat", 32'(rsp_dat), 9);
      end
    end
    chk("both_ack_k", ack_k, 3);
    chk("both_rsp_k", rsp_k, 9);
    @(negedge clk);

    // seed_req raised mid-word waits for the next IDLE
    seed_load(25'h0000001, 25'h0000001, 1'b0);
    req_vld = 2'b10; cfg_steps = 5'd3;
    ack_k = 0; rsp_k = 0;
    for (k = 1; k <= 30 && ack_k == 0; k++) begin
      @(negedge clk);
      if (k == 2) begin
        seed_req = 1'b1;
        seed_dat = 25'h1000000;
      end
      if (dbg_state == 3'd1) seed_req = 1'b0;
      if (rsp_vld != '0) begin
        rsp_k = k;
        req_vld = '0;
        chk("mid_rsp_vld", 32'(rsp_vld), 2);
        chk("mid_rsp_dat", 32'(rsp_dat), 9);
      end
      if (seed_ack) begin
        ack_k = k;
        chk("mid_seed_r_dat", 32'(prng_r_dat), 32'h1000000);
      end
    end
    chk("mid_rsp_k", rsp_k, 5);
    chk("mid_ack_k", ack_k, 9);
    seed_req = 1'b0;
    @(negedge clk);

    // reset asserted during SHIFT
    req_vld = 2'b01; cfg_steps = 5'd0;
    repeat (3) @(negedge clk);
    chk("pre_rst_shift", 32'(dbg_state), 4);
    rst_b = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midrst");
    rst_b = 1'b1; req_vld = '0;
    @(negedge clk);
    chk("post_rst_idle", 32'(dbg_state), 0);

    // both requesters held: grants alternate 0,1,0,1 from rr pointer 0
    req_vld = 2'b11; cfg_steps = 5'd1; cnt = 0; last_k = 0;
    for (k = 1; k <= 40 && cnt < 4; k++) begin
      @(negedge clk);
      if (rsp_vld != '0) begin
        chk("alt_grant", 32'(rsp_vld), 32'(1) << (cnt % 2));
        chk("alt_gap", k - last_k, (cnt == 0) ? 3 : 4);
        chk("alt_dat", 32'(rsp_dat), 0);
        last_k = k;
        cnt++;
        if (cnt == 4) req_vld = '0;
      end
    end
    chk("alt_count", cnt, 4);
    @(negedge clk);
    chk("alt_idle", 32'(dbg_state), 0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
